// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: shadows dst/Tnew through E, M and W,
// decides D-stage stalls, tracks mult/div occupancy and drives the D/E forwarding selects.
module hazard_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [1:0] TuseRs_D,
  input  logic [1:0] TuseRt_D,
  input  logic [4:0] Dst_D,
  input  logic [1:0] Tnew_D,
  input  logic       StartMD_D,
  input  logic       IsDiv_D,
  input  logic       UsesMD_D,
  output logic       Stall,
  output logic [1:0] ForwardRSD,
  output logic [1:0] ForwardRTD,
  output logic [1:0] ForwardRSE,
  output logic [1:0] ForwardRTE,
  output logic       MDBusy
);

  logic [4:0] e_rs_p0, e_rt_p0, e_dst_p0;
  logic [1:0] e_tnew_p0;
  logic       e_md_p0, e_div_p0;
  logic [4:0] m_dst_p1;
  logic [1:0] m_tnew_p1;
  logic [4:0] w_dst_p2;
  logic [3:0] cnt;
  logic       md_stall;

  function automatic logic [1:0] sat0_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic [4:0] dst);
    return (r != 5'd0) && (r == dst);
  endfunction

  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                     input logic [4:0] m_dst, input logic [1:0] m_tnew);
    return (tuse != 2'd3) &&
           ((hit(r, e_dst) && (e_tnew > tuse)) || (hit(r, m_dst) && (m_tnew > tuse)));
  endfunction

  // M wins over W so the youngest producer of a register is the one forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] m_dst,
                                         input logic [1:0] m_tnew, input logic [4:0] w_dst);
    if (hit(r, m_dst) && (m_tnew == 2'd0)) return 2'b10;
    else if (hit(r, w_dst))                return 2'b01;
    else                                   return 2'b00;
  endfunction

  assign md_stall = UsesMD_D && ((cnt != 4'd0) || e_md_p0);
  assign Stall    = src_stall(Rs_D, TuseRs_D, e_dst_p0, e_tnew_p0, m_dst_p1, m_tnew_p1) ||
                    src_stall(Rt_D, TuseRt_D, e_dst_p0, e_tnew_p0, m_dst_p1, m_tnew_p1) ||
                    md_stall;
  assign MDBusy     = (cnt != 4'd0) || e_md_p0;
  assign ForwardRSD = fwd_sel(Rs_D, m_dst_p1, m_tnew_p1, w_dst_p2);
  assign ForwardRTD = fwd_sel(Rt_D, m_dst_p1, m_tnew_p1, w_dst_p2);
  assign ForwardRSE = fwd_sel(e_rs_p0, m_dst_p1, m_tnew_p1, w_dst_p2);
  assign ForwardRTE = fwd_sel(e_rt_p0, m_dst_p1, m_tnew_p1, w_dst_p2);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      e_rs_p0   <= '0;
      e_rt_p0   <= '0;
      e_dst_p0  <= '0;
      e_tnew_p0 <= '0;
      e_md_p0   <= 1'b0;
      e_div_p0  <= 1'b0;
      m_dst_p1  <= '0;
      m_tnew_p1 <= '0;
      w_dst_p2  <= '0;
      cnt       <= '0;
    end else begin
      // D -> E: a stalled instruction leaves a bubble behind it
      if (Stall) begin
        e_rs_p0   <= '0;
        e_rt_p0   <= '0;
        e_dst_p0  <= '0;
        e_tnew_p0 <= '0;
        e_md_p0   <= 1'b0;
        e_div_p0  <= 1'b0;
      end else begin
        e_rs_p0   <= Rs_D;
        e_rt_p0   <= Rt_D;
        e_dst_p0  <= Dst_D;
        e_tnew_p0 <= Tnew_D;
        e_md_p0   <= StartMD_D;
        e_div_p0  <= IsDiv_D;
      end
      // E -> M
      m_dst_p1  <= e_dst_p0;
      m_tnew_p1 <= sat0_dec(e_tnew_p0);
      // M -> W
      w_dst_p2  <= m_dst_p1;
      if (e_md_p0)
        cnt <= e_div_p0 ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed hazard sequences followed by randomized
// instruction streams, checked against an age-based model of in-flight instructions.
module tb_hazard_sched;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] Rs_D, Rt_D, Dst_D;
  logic [1:0] TuseRs_D, TuseRt_D, Tnew_D;
  logic       StartMD_D, IsDiv_D, UsesMD_D;
  logic       Stall, MDBusy;
  logic [1:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;

  hazard_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .Reset(Reset), .Rs_D(Rs_D), .Rt_D(Rt_D),
    .TuseRs_D(TuseRs_D), .TuseRt_D(TuseRt_D), .Dst_D(Dst_D), .Tnew_D(Tnew_D),
    .StartMD_D(StartMD_D), .IsDiv_D(IsDiv_D), .UsesMD_D(UsesMD_D),
    .Stall(Stall), .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
    .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE), .MDBusy(MDBusy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: every instruction that entered E, stamped with its entry cycle.
  typedef struct {
    int rs, rt, dst, tnew, entry;
  } ins_t;
  ins_t q[$];
  int   cyc = 0;
  int   md_end = -1;   // last cycle the mult/div unit is busy

  function automatic int remaining(ins_t i);
    int r = i.tnew - (cyc - i.entry);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit m_stall_src(int r, int tuse);
    if (r == 0 || tuse == 3) return 0;
    foreach (q[k]) begin
      int age = cyc - q[k].entry;
      if (age <= 1 && q[k].dst == r && remaining(q[k]) > tuse) return 1;
    end
    return 0;
  endfunction

  function automatic int m_fwd(int r);
    if (r == 0) return 0;
    foreach (q[k])
      if (cyc - q[k].entry == 1 && q[k].dst == r && remaining(q[k]) == 0) return 2;
    foreach (q[k])
      if (cyc - q[k].entry == 2 && q[k].dst == r) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_e(bit use_rt);
    foreach (q[k])
      if (q[k].entry == cyc) return m_fwd(use_rt ? q[k].rt : q[k].rs);
    return 0;
  endfunction

  logic obs_stall, obs_busy;
  logic [1:0] obs_rsd, obs_rtd, obs_rse, obs_rte;
  bit   exp_stall;

  task automatic drive(input int rs, input int rt, input int tur, input int tut,
                       input int dst, input int tnew, input bit smd, input bit isdiv,
                       input bit umd);
    Rs_D = 5'(rs); Rt_D = 5'(rt); TuseRs_D = 2'(tur); TuseRt_D = 2'(tut);
    Dst_D = 5'(dst); Tnew_D = 2'(tnew);
    StartMD_D = smd; IsDiv_D = isdiv; UsesMD_D = umd;
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit eb;
    @(negedge CLK);
    eb = (cyc <= md_end);
    exp_stall = m_stall_src(int'(Rs_D), int'(TuseRs_D)) ||
                m_stall_src(int'(Rt_D), int'(TuseRt_D)) || (UsesMD_D && eb);
    obs_stall = Stall; obs_busy = MDBusy;
    obs_rsd = ForwardRSD; obs_rtd = ForwardRTD; obs_rse = ForwardRSE; obs_rte = ForwardRTE;
    chk("stall", 8'(Stall), 8'(exp_stall));
    chk("mdbusy", 8'(MDBusy), 8'(eb));
    chk("fwd_rsd", 8'(ForwardRSD), 8'(m_fwd(int'(Rs_D))));
    chk("fwd_rtd", 8'(ForwardRTD), 8'(m_fwd(int'(Rt_D))));
    chk("fwd_rse", 8'(ForwardRSE), 8'(m_fwd_e(0)));
    chk("fwd_rte", 8'(ForwardRTE), 8'(m_fwd_e(1)));
    @(posedge CLK);
    if (Reset) begin
      q.delete();
      md_end = -1;
    end else if (!exp_stall) begin
      q.push_back('{rs: int'(Rs_D), rt: int'(Rt_D), dst: int'(Dst_D),
                    tnew: int'(Tnew_D), entry: cyc + 1});
      if (StartMD_D) md_end = cyc + 1 + (IsDiv_D ? 10 : 5);
    end
    cyc++;
    while (q.size() > 0 && cyc - q[0].entry > 2) void'(q.pop_front());
    #1;
  endtask

  initial begin
    int nst;
    bool_loop: begin end
    Reset = 1'b1;
    nop();
    @(posedge CLK); #1;
    cyc++;
    Reset = 1'b0;

    // Reset state with idle inputs
    tick();
    chk("rst_stall", 8'(obs_stall), 8'd0);
    chk("rst_busy", 8'(obs_busy), 8'd0);
    chk("rst_fwd", 8'({obs_rsd, obs_rtd, obs_rse, obs_rte}), 8'd0);

    // addu $8 then beq on $8
    drive(1, 2, 1, 1, 8, 1, 0, 0, 0); tick();
    drive(8, 0, 0, 3, 0, 0, 0, 0, 0); tick();
    chk("beq_alu_stall", 8'(obs_stall), 8'd1);
    tick();
    chk("beq_alu_go", 8'(obs_stall), 8'd0);
    chk("beq_alu_fwd", 8'(obs_rsd), 8'd2);
    nop(); tick(); tick(); tick();

    // lw $9 then addu using $9 in E
    drive(1, 0, 1, 3, 9, 2, 0, 0, 0); tick();
    drive(9, 0, 1, 3, 10, 1, 0, 0, 0); tick();
    chk("lw_use_stall", 8'(obs_stall), 8'd1);
    tick();
    chk("lw_use_go", 8'(obs_stall), 8'd0);
    nop(); tick();
    chk("lw_use_fwd_e", 8'(obs_rse), 8'd1);
    tick(); tick();

    // lw $9, nop, beq on rt=$9
    drive(1, 0, 1, 3, 9, 2, 0, 0, 0); tick();
    nop(); tick();
    drive(0, 9, 3, 0, 0, 0, 0, 0, 0); tick();
    chk("lw_nop_beq_stall", 8'(obs_stall), 8'd1);
    tick();
    chk("lw_nop_beq_go", 8'(obs_stall), 8'd0);
    chk("lw_nop_beq_fwd", 8'(obs_rtd), 8'd1);
    nop(); tick(); tick(); tick();

    // div then mflo
    drive(4, 5, 1, 1, 0, 0, 1, 1, 1); tick();
    drive(0, 0, 3, 3, 6, 1, 0, 0, 1);
    nst = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!obs_stall) break;
      nst++;
    end
    chk("div_stall_cycles", 8'(nst), 8'd11);
    chk("div_busy_falls", 8'(obs_busy), 8'd0);
    nop(); tick(); tick(); tick();

    // writes to $0 never stall or forward
    drive(1, 2, 1, 1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("r0_stall", 8'(obs_stall), 8'd0);
    chk("r0_fwd", 8'(obs_rsd), 8'd0);

    // reset in the middle of a mult
    drive(4, 5, 1, 1, 0, 0, 1, 0, 1); tick();
    nop(); tick(); tick();
    Reset = 1'b1; tick();
    Reset = 1'b0; tick();
    chk("rst_mid_md_busy", 8'(obs_busy), 8'd0);

    // Randomized instruction stream; a stalled instruction is held in D
    exp_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!exp_stall || Reset) begin
        int kind = $urandom_range(0, 9);
        int r1 = $urandom_range(0, 3);
        int r2 = $urandom_range(0, 3);
        if (kind == 0)
          drive(r1, r2, 1, 1, 0, 0, 1, 1'($urandom_range(0, 1)), 1);
        else if (kind == 1)
          drive(0, 0, 3, 3, $urandom_range(0, 3), 1, 0, 0, 1);
        else
          drive(r1, r2, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(1, 2), 0, 0, 0);
      end
      Reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core. It tracks a shadow copy of the destination register and remaining result latency (Tnew) for the E, M and W stages, plus a multiply/divide busy counter.
- Each cycle it decides whether the instruction in D must stall, and drives the D-stage and E-stage forwarding selects.
- The D-stage selects feed the MFRSD/MFRTD muxes: 00 GRF, 01 W write-back data, 10 ALUOutput_M.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after entering E
- DIV_CYCLES, 10, busy cycles for div/divu after entering E

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Rs_D  in  5  rs field of instruction in D
- Rt_D  in  5  rt field of instruction in D
- TuseRs_D  in  2  cycles until D instr needs rs (0 = branch/jr in D, 1 = ALU in E, 2 = store data in M, 3 = not used)
- TuseRt_D  in  2  same for rt
- Dst_D  in  5  register written by D instr (0 = no write)
- Tnew_D  in  2  cycles after entering E until result is forwardable (ALU/lui/link = 1, load = 2)
- StartMD_D  in  1  D instr is mult/multu/div/divu
- IsDiv_D  in  1  qualifies StartMD_D as div
- UsesMD_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- Stall  out  1  freeze PC and D register, insert bubble into E
- ForwardRSD  out  2  D-stage rs select
- ForwardRTD  out  2  D-stage rt select
- ForwardRSE  out  2  E-stage rs select (00 register value, 01 W data, 10 ALUOutput_M)
- ForwardRTE  out  2  E-stage rt select
- MDBusy  out  1  mult/div unit busy

Behaviour:
- State: shadow stages E, M and W, each holding {rs, rt, dst[4:0], tnew[1:0]}. The W stage needs only dst. State also includes MD counter cnt[3:0].
- Reset (synchronous): all shadow fields 0, cnt 0. Outputs are combinational from state and inputs; with inputs 0 after reset, Stall = 0, MDBusy = 0, all forwards = 00.
- Advance every cycle:
  - M <= E with tnew = sat0(tnew_E - 1).
  - W <= M.
  - E <= {Rs_D, Rt_D, Dst_D, Tnew_D} when Stall = 0; otherwise E <= bubble (all zero).
- Match rule: source r matches stage X iff r != 0 and r == dst_X.
- Data stall for source r with Tuse t:
  - (match E and tnew_E > t), or
  - (match M and sat0(tnew_E-derived) tnew_M > t).
  - Tuse 3 never stalls.
- MD stall: UsesMD_D and (cnt != 0 or E holds an MD start).
- E holds an MD start via a 1-bit shadow flag md_E, set from StartMD_D when not stalling.
- Stall = data stall(rs) or data stall(rt) or MD stall.
- MD counter:
  - When md_E = 1, cnt <= IsDiv_E ? DIV_CYCLES : MULT_CYCLES (the IsDiv shadow travels with md_E).
  - Otherwise, if cnt != 0, cnt <= cnt - 1.
  - MDBusy = (cnt != 0) | md_E.
- ForwardRSD / ForwardRTD: 10 if match M and tnew_M == 0; else 01 if match W; else 00. M has priority over W. Stall does not suppress forwarding.
- ForwardRSE / ForwardRTE: use rs_E/rt_E. 10 if match M and tnew_M == 0; else 01 if match W; else 00.
- Register 0 never forwards and never stalls.
- Simultaneous stall and MD completion: counter still decrements.
- Reset mid-MD operation clears cnt immediately.

Test Plan:
- Reset high 1 cycle, then all inputs 0 -> Stall = 0, MDBusy = 0, all Forward* = 00.
- addu dst 8, Tnew 1, then beq Rs = 8, TuseRs 0 -> cycle 1: Stall = 1. Cycle 2 (addu in M): Stall = 0, ForwardRSD = 10.
- lw dst 9, Tnew 2, then addu Rs = 9, TuseRs 1 -> exactly 1 stall cycle. Next cycle: ForwardRSE = 01 while the addu is in E.
- lw dst 9, then nop, then beq Rt = 9, TuseRt 0 -> 1 stall (lw in M, tnew 1). Then ForwardRTD = 01.
- div (IsDiv = 1), then mflo -> Stall high for 11 cycles (E-entry cycle + 10). MDBusy falls the same cycle Stall falls.
- addu dst 0, then beq Rs = 0 -> no stall; ForwardRSD = 00.
